// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Pipelined instruction fetch unit. Owns the program counter, issues one word
// fetch per cycle to an instruction memory whose responses come back in
// request order after any latency of at least one cycle, and buffers the
// returned words (each tagged with its word PC) in a small queue that feeds
// decode. Branch, jump and jump-register redirects flush the queue and mark
// every fetch still in flight as stale so its response is thrown away.
//
// Parameters
//   PC_WIDTH  word-address width of the PC (byte address = {pc, 2'b00});
//             at most 30 so a jump-register target fits in redirect_reg.
//   RESET_PC  word address fetched first after reset.
//   QDEPTH    queue entries, and the cap on queued + in-flight fetches;
//             power of two, at least 2.
//
// Ports
//   clk, rst_n       clock (posedge) and asynchronous active-low reset
//   imem_req         fetch request this cycle (the memory always accepts)
//   imem_addr        byte address of the request
//   imem_rvalid      response valid; responses arrive in request order
//   imem_rdata       response instruction word
//   inst_valid       queue head valid
//   inst, inst_pc    queue head instruction and its word PC
//   inst_ready       decode takes the head when inst_valid && inst_ready
//   redirect_valid   redirect this cycle
//   redirect_kind    00 branch, 01 jump, 10 jump-register, 11 as 10
//   redirect_pc      word PC of the redirecting instruction
//   redirect_imm16   signed branch offset in words
//   redirect_addr26  jump target field
//   redirect_reg     jump-register byte target; bits [1:0] ignored
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                  PC_WIDTH = 30,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  QDEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH+1:0] imem_addr,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output logic [PC_WIDTH-1:0] inst_pc,
    input  logic                inst_ready,
    input  logic                redirect_valid,
    input  logic [1:0]          redirect_kind,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic [15:0]         redirect_imm16,
    input  logic [25:0]         redirect_addr26,
    input  logic [31:0]         redirect_reg
);

    // Counter width holds 0..QDEPTH; queue pointers carry one extra wrap bit,
    // which for a power-of-two depth is the same width.
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);

    // Branch arithmetic is done at least 16 bits wide so the offset keeps
    // its sign before the result is cut back to PC_WIDTH.
    localparam int EW = (PC_WIDTH > 16) ? PC_WIDTH : 16;

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'b00,
        KIND_JUMP   = 2'b01,
        KIND_JR     = 2'b10,
        KIND_RSVD   = 2'b11
    } redirect_kind_e;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         word;
    } q_entry_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                r_run;       // low in reset, high from the first edge after
    logic [PC_WIDTH-1:0] r_pc;        // next word address to request
    logic [PC_WIDTH-1:0] r_resp_pc;   // word address of the next kept response
    logic [CW-1:0]       r_out;       // requests issued, response not yet seen
    logic [CW-1:0]       r_drop;      // of r_out, how many are stale
    logic [CW-1:0]       r_wptr;
    logic [CW-1:0]       r_rptr;
    q_entry_t            r_mem [QDEPTH];

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic [CW-1:0]       w_count;
    logic [CW:0]         w_in_use;
    logic                w_issue;
    logic                w_rsp;
    logic                w_push;
    logic                w_pop;
    logic [EW-1:0]       w_imm_ext;
    logic [EW-1:0]       w_br_sum;
    logic [PC_WIDTH-1:0] w_br_target;
    logic [PC_WIDTH-1:0] w_j_target;
    logic [PC_WIDTH-1:0] w_jr_target;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_unused;

    assign w_count  = r_wptr - r_rptr;
    assign w_in_use = {1'b0, w_count} + {1'b0, r_out};

    // Queue space is reserved at issue time, so a response can always be
    // pushed without back-pressure. r_run keeps the request low while in reset.
    assign w_issue = r_run && !redirect_valid && (w_in_use < QD);

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp  = imem_rvalid && (r_out != '0);
    assign w_push = w_rsp && !redirect_valid && (r_drop == '0);
    assign w_pop  = inst_valid && inst_ready;

    // -------------------------------------------------------------------------
    // Redirect target
    // -------------------------------------------------------------------------
    assign w_imm_ext   = EW'($signed(redirect_imm16));
    assign w_br_sum    = EW'(redirect_pc) + EW'(1) + w_imm_ext;
    assign w_br_target = w_br_sum[PC_WIDTH-1:0];
    assign w_jr_target = redirect_reg[PC_WIDTH+1:2];

    generate
        if (PC_WIDTH > 26) begin : g_jump_wide
            assign w_j_target = {redirect_pc[PC_WIDTH-1:26], redirect_addr26};
        end else begin : g_jump_narrow
            assign w_j_target = redirect_addr26[PC_WIDTH-1:0];
        end
    endgenerate

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_target = w_jr_target;
        case (redirect_kind_e'(redirect_kind))
            KIND_BRANCH: w_target = w_br_target;
            KIND_JUMP:   w_target = w_j_target;
            default:     w_target = w_jr_target;
        endcase
    end

    // Bits that are deliberately not part of any target.
    assign w_unused = ^{redirect_reg, w_br_sum};

    // -------------------------------------------------------------------------
    // Run flag and PC registers
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_target;
        end else if (w_issue) begin
            r_pc <= r_pc + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_resp_pc <= w_target;
        end else if (w_push) begin
            r_resp_pc <= r_resp_pc + PC_WIDTH'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Outstanding and stale-response counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= r_out + CW'(w_issue) - CW'(w_rsp);
        end
    end

    // On a redirect every fetch still in flight becomes stale. r_out already
    // includes the ones marked stale by an earlier redirect, so the new drop
    // count is r_out itself (less a response consumed this cycle), which keeps
    // back-to-back redirects from counting the same fetch twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (redirect_valid) begin
            r_drop <= r_out - CW'(w_rsp);
        end else if (w_rsp && (r_drop != '0)) begin
            r_drop <= r_drop - CW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Instruction queue
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (redirect_valid) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + CW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + CW'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; an entry is only read once the
    // pointers say it was written, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[PW-1:0]] <= '{pc: r_resp_pc, word: imem_rdata};
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_req   = w_issue;
    assign imem_addr  = {r_pc, 2'b00};
    assign inst_valid = (w_count != '0);
    assign inst       = r_mem[r_rptr[PW-1:0]].word;
    assign inst_pc    = r_mem[r_rptr[PW-1:0]].pc;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A memory model answers requests in order
// after a programmable latency. A monitor keeps a model of the fetch stream:
// every request must carry the model's next address, and its expected
// {pc, word} goes into a scoreboard queue that is popped and compared each
// time decode consumes the queue head. Redirects and reset re-aim the model
// and empty the scoreboard, so any stale instruction reaching decode shows up.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int PC_WIDTH = 30;
    localparam int QDEPTH   = 4;
    localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         word;
    } sb_entry_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                imem_req;
    logic [PC_WIDTH+1:0] imem_addr;
    logic                imem_rvalid;
    logic [31:0]         imem_rdata;
    logic                inst_valid;
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] inst_pc;
    logic                inst_ready;
    logic                redirect_valid;
    logic [1:0]          redirect_kind;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic [15:0]         redirect_imm16;
    logic [25:0]         redirect_addr26;
    logic [31:0]         redirect_reg;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model state
    pend_t pend_q[$];
    pend_t pend_e;
    int    mem_cyc = 0;
    int    mem_lat = 1;
    logic  inject  = 1'b0;

    // Fetch-stream model and scoreboard
    sb_entry_t           sb_q[$];
    sb_entry_t           exp_e;
    logic [PC_WIDTH-1:0] model_pc   = RESET_PC;
    logic [PC_WIDTH-1:0] exp_target = '0;
    int                  req_count  = 0;
    int                  base;

    fetch_unit #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .redirect_valid  (redirect_valid),
        .redirect_kind   (redirect_kind),
        .redirect_pc     (redirect_pc),
        .redirect_imm16  (redirect_imm16),
        .redirect_addr26 (redirect_addr26),
        .redirect_reg    (redirect_reg)
    );

    initial forever #5 clk = ~clk;

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [PC_WIDTH-1:0] w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive point: just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample point: after the falling edge, once the monitor has run.
    task automatic look();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_req(input string tag, input int max_cyc);
        int n = 0;
        look();
        while (!imem_req && n < max_cyc) begin
            look();
            n++;
        end
        check(tag, imem_req, 1'b1);
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n = 0;
        look();
        while (!inst_valid && n < max_cyc) begin
            look();
            n++;
        end
        check(tag, inst_valid, 1'b1);
    endtask

    task automatic do_redirect(input logic [1:0] kind, input logic [PC_WIDTH-1:0] rpc,
                               input logic [15:0] imm, input logic [25:0] a26,
                               input logic [31:0] rreg, input logic [PC_WIDTH-1:0] tgt);
        redirect_valid  = 1'b1;
        redirect_kind   = kind;
        redirect_pc     = rpc;
        redirect_imm16  = imm;
        redirect_addr26 = a26;
        redirect_reg    = rreg;
        exp_target      = tgt;
        step();
        redirect_valid  = 1'b0;
    endtask

    // Memory: in-order responses, each no earlier than mem_lat cycles after
    // its request; optionally one unsolicited response when idle.
    initial begin : mem_model
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_cyc++;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (pend_q.size() != 0 && pend_q[0].due <= mem_cyc) begin
                pend_e      = pend_q.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_e.addr[PC_WIDTH+1:2]);
            end else if (inject) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
                inject      = 1'b0;
            end
            if (imem_req) begin
                pend_q.push_back('{addr: imem_addr, due: mem_cyc + mem_lat});
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                model_pc = RESET_PC;
                sb_q.delete();
            end else begin
                if (imem_req) begin
                    req_count++;
                    check("req_in_redirect_cycle", redirect_valid, 1'b0);
                    check("imem_addr", imem_addr, {model_pc, 2'b00});
                    sb_q.push_back('{pc: model_pc, word: mem_word(model_pc)});
                    model_pc = model_pc + 1'b1;
                end
                if (inst_valid && inst_ready) begin
                    check("sb_has_entry", sb_q.size() != 0, 1'b1);
                    if (sb_q.size() != 0) begin
                        exp_e = sb_q.pop_front();
                        check("inst_pc", inst_pc, exp_e.pc);
                        check("inst", inst, exp_e.word);
                    end
                end
                if (redirect_valid) begin
                    model_pc = exp_target;
                    sb_q.delete();
                end
            end
        end
    end

    initial begin : stimulus
        rst_n           = 1'b0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_kind   = 2'b00;
        redirect_pc     = '0;
        redirect_imm16  = '0;
        redirect_addr26 = '0;
        redirect_reg    = '0;
        mem_lat         = 1;

        // 1: reset state, then L=1 streaming with first-fetch latency.
        repeat (3) step();
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_imem_addr", imem_addr, 32'h0);
        inst_ready = 1'b1;
        rst_n      = 1'b1;
        wait_req("t1_first_req", 5);
        check("t1_first_addr", imem_addr, 32'h0);
        look();
        check("t1_valid_t_plus_1", inst_valid, 1'b0);
        look();
        check("t1_valid_t_plus_2", inst_valid, 1'b1);
        check("t1_head_pc", inst_pc, 0);
        for (int i = 0; i < 8; i++) begin
            look();
            check("t1_req_every_cycle", imem_req, 1'b1);
        end

        // 2: decode stalled, L=3: exactly QDEPTH requests, head held.
        step();
        rst_n = 1'b0;
        repeat (6) step();
        mem_lat    = 3;
        inst_ready = 1'b0;
        base       = req_count;
        rst_n      = 1'b1;
        repeat (15) look();
        check("t2_req_total", req_count - base, QDEPTH);
        check("t2_req_stopped", imem_req, 1'b0);
        check("t2_head_valid", inst_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            look();
            check("t2_head_pc_held", inst_pc, 0);
            check("t2_head_inst_held", inst, mem_word(0));
        end

        // 3: branch with fetches in flight at L=2: 5 + 1 - 2 = 4.
        step();
        inst_ready = 1'b1;
        mem_lat    = 2;
        repeat (10) step();
        do_redirect(2'b00, 30'd5, 16'hFFFE, 26'h0, 32'h0, 30'd4);
        look();
        check("t3_next_req", imem_req, 1'b1);
        check("t3_next_addr", imem_addr, 32'h10);
        wait_valid("t3_wait_valid", 12);
        check("t3_first_pc", inst_pc, 30'd4);
        repeat (6) step();

        // 4: jump keeps the PC's top bits; then branch+jr back-to-back at L=3.
        mem_lat = 3;
        repeat (8) step();
        do_redirect(2'b01, 30'h3C00_0000, 16'h0, 26'h10, 32'h0, 30'h3C00_0010);
        look();
        check("t4_jump_req", imem_req, 1'b1);
        check("t4_jump_addr", imem_addr, 32'hF000_0040);
        repeat (8) step();
        do_redirect(2'b00, 30'h100, 16'h0010, 26'h0, 32'h0, 30'h111);
        do_redirect(2'b10, 30'h0, 16'h0, 26'h0, 32'h0000_0103, 30'h40);
        look();
        check("t4_jr_addr", imem_addr, 32'h100);
        wait_valid("t4_wait_valid", 12);
        check("t4_first_pc", inst_pc, 30'h40);
        repeat (8) step();

        // 5: redirect (reserved kind = jr) while a response arrives and the head pops.
        mem_lat = 1;
        repeat (6) step();
        redirect_valid = 1'b1;
        redirect_kind  = 2'b11;
        redirect_reg   = 32'h0000_0200;
        exp_target     = 30'h80;
        look();
        check("t5_rvalid_same_cycle", imem_rvalid, 1'b1);
        check("t5_pop_same_cycle", inst_valid && inst_ready, 1'b1);
        check("t5_no_issue", imem_req, 1'b0);
        step();
        redirect_valid = 1'b0;
        wait_valid("t5_wait_valid", 8);
        check("t5_first_pc", inst_pc, 30'h80);
        repeat (4) step();

        // 6: PC wrap, then reset mid-burst.
        do_redirect(2'b10, 30'h0, 16'h0, 26'h0, 32'hFFFF_FFFF, 30'h3FFF_FFFF);
        look();
        check("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
        look();
        check("t6_wrap_req", imem_req, 1'b1);
        check("t6_wrap_addr", imem_addr, 32'h0);
        repeat (4) step();
        check("t6_pre_reset_valid", inst_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_reset_req", imem_req, 1'b0);
        check("t6_reset_valid", inst_valid, 1'b0);
        check("t6_reset_addr", imem_addr, 32'h0);
        repeat (6) step();
        rst_n = 1'b1;
        wait_req("t6_restart_req", 5);
        check("t6_restart_addr", imem_addr, 32'h0);
        wait_valid("t6_restart_valid", 6);
        check("t6_restart_pc", inst_pc, 0);

        // 7: unsolicited response with nothing outstanding is ignored.
        step();
        inst_ready = 1'b0;
        repeat (10) step();
        check("t7_full_no_req", imem_req, 1'b0);
        inject = 1'b1;
        repeat (3) look();
        check("t7_inject_consumed", inject, 1'b0);
        check("t7_still_no_req", imem_req, 1'b0);
        step();
        inst_ready = 1'b1;
        wait_req("t7_resume_req", 8);
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
